// File: rtl/tsc_sequencer.sv
// -----------------------------------------------------------------------------
// tsc_sequencer
//   Arms a trigger-surround cache (TSC), paces ADC sample requests while it
//   waits for a trigger, latches the trigger timestamp and streams the cached
//   frame bytes downstream with valid/ready backpressure.
//
// Ports
//   clk, reset        single clock; asynchronous active-low reset
//   en                continuous-arm enable
//   adc_req           one-cycle ADC sample request (WAIT_TRIG / WAIT_CD only)
//   tsc_start         one-cycle cache start pulse (ARM state)
//   tsc_trd, tsc_cd   cache trigger-detected / capture-done flags
//   tsc_trigtm        trigger timestamp, valid while tsc_cd=1
//   tsc_sbf           send-buffer request to the cache
//   tsc_rdy, tsc_dat  cache byte strobe and byte data
//   tsc_sd            cache send-done flag
//   out_valid/out_data/out_last/out_ready   downstream byte stream
//   ts_data, ts_valid latched timestamp and its one-cycle qualifier
//   busy, err_timeout, err_short           status
//   state             current state encoding
// -----------------------------------------------------------------------------
module tsc_sequencer #(
  parameter int SAMPLE_DIV  = 4,
  parameter int CACHE_DEPTH = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        adc_req,
  output logic        tsc_start,
  input  logic        tsc_trd,
  input  logic        tsc_cd,
  input  logic [31:0] tsc_trigtm,
  output logic        tsc_sbf,
  input  logic        tsc_rdy,
  input  logic [7:0]  tsc_dat,
  input  logic        tsc_sd,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [31:0] ts_data,
  output logic        ts_valid,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_short,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_WAIT_CD   = 3'd3,
    S_READOUT   = 3'd4,
    S_DRAIN     = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [7:0]  CNT_LAST = 8'(CACHE_DEPTH);
  localparam logic [7:0]  DIV_LAST = 8'(SAMPLE_DIV - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      cur_st, nxt_st;
  logic [7:0]  byte_cnt;
  logic [7:0]  div_cnt;
  logic [15:0] tmo_cnt;
  logic        latch_ts, set_tmo, set_short;
  logic        load, accept, in_wait, nxt_wait;
  logic [7:0]  cnt_inc;

  assign state     = cur_st;
  assign busy      = (cur_st != S_IDLE);
  assign tsc_start = (cur_st == S_ARM);
  // Withdraw the send request in the same cycle a held byte is stalled, so
  // the cache never presents a byte we have no room for.
  assign tsc_sbf   = (cur_st == S_READOUT) && !(out_valid && !out_ready);
  assign load      = tsc_rdy && tsc_sbf;
  assign accept    = out_valid && out_ready;
  assign cnt_inc   = byte_cnt + 8'd1;
  assign in_wait   = (cur_st == S_WAIT_TRIG) || (cur_st == S_WAIT_CD);
  assign nxt_wait  = (nxt_st == S_WAIT_TRIG) || (nxt_st == S_WAIT_CD);

  always_comb begin
    nxt_st    = cur_st;
    latch_ts  = 1'b0;
    set_tmo   = 1'b0;
    set_short = 1'b0;
    case (cur_st)
      S_IDLE:      if (en) nxt_st = S_ARM;
      S_ARM:       nxt_st = S_WAIT_TRIG;
      S_WAIT_TRIG: begin
        if (tsc_trd && tsc_cd) begin
          nxt_st   = S_READOUT;
          latch_ts = 1'b1;
        end else if (tsc_trd) begin
          nxt_st = S_WAIT_CD;
        end else if (!en) begin
          nxt_st = S_IDLE;
        end
      end
      S_WAIT_CD: begin
        if (tsc_cd) begin
          nxt_st   = S_READOUT;
          latch_ts = 1'b1;
        end else if (tmo_cnt == TMO_LAST) begin
          nxt_st  = S_ERROR;
          set_tmo = 1'b1;
        end
      end
      S_READOUT: begin
        // A byte arriving with send-done is counted before judging shortness.
        if (load && (cnt_inc == CNT_LAST)) begin
          nxt_st = S_DRAIN;
        end else if (tsc_sd) begin
          nxt_st    = S_DRAIN;
          set_short = 1'b1;
        end
      end
      S_DRAIN:     if (!out_valid) nxt_st = en ? S_ARM : S_IDLE;
      S_ERROR:     if (!en) nxt_st = S_IDLE;
      default:     nxt_st = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_st      <= S_IDLE;
      byte_cnt    <= '0;
      div_cnt     <= '0;
      tmo_cnt     <= '0;
      adc_req     <= 1'b0;
      ts_data     <= '0;
      ts_valid    <= 1'b0;
      err_timeout <= 1'b0;
      err_short   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      cur_st   <= nxt_st;
      ts_valid <= latch_ts;
      if (latch_ts) ts_data <= tsc_trigtm;

      // Divider runs only while waiting; it is zero on WAIT_TRIG entry since
      // that state is only entered from ARM. The pulse is registered so it
      // lands SAMPLE_DIV cycles after entry, and only if we stay waiting.
      if (in_wait) div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      else         div_cnt <= '0;
      adc_req <= in_wait && nxt_wait && (div_cnt == DIV_LAST);

      if (cur_st == S_WAIT_CD) tmo_cnt <= sat_inc16(tmo_cnt);
      else                     tmo_cnt <= '0;

      if (cur_st == S_ARM) begin
        err_timeout <= 1'b0;
        err_short   <= 1'b0;
        byte_cnt    <= '0;
      end else begin
        if (set_tmo)   err_timeout <= 1'b1;
        if (set_short) err_short   <= 1'b1;
        if (load)      byte_cnt    <= cnt_inc;
      end

      // A load may coincide with an accept of the previous byte (no bubble).
      if (load) begin
        out_data  <= tsc_dat;
        out_valid <= 1'b1;
        out_last  <= (cnt_inc == CNT_LAST);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tsc_sequencer.sv
module tb_tsc_sequencer;
  localparam int SAMPLE_DIV  = 4;
  localparam int CACHE_DEPTH = 32;
  localparam int TIMEOUT     = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en, adc_req, tsc_start, tsc_trd, tsc_cd, tsc_sbf, tsc_rdy, tsc_sd;
  logic [31:0] tsc_trigtm, ts_data;
  logic [7:0]  tsc_dat, out_data;
  logic        out_valid, out_last, out_ready, ts_valid, busy, err_timeout, err_short;
  logic [2:0]  state;

  tsc_sequencer #(.SAMPLE_DIV(SAMPLE_DIV), .CACHE_DEPTH(CACHE_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .en(en), .adc_req(adc_req), .tsc_start(tsc_start),
    .tsc_trd(tsc_trd), .tsc_cd(tsc_cd), .tsc_trigtm(tsc_trigtm), .tsc_sbf(tsc_sbf),
    .tsc_rdy(tsc_rdy), .tsc_dat(tsc_dat), .tsc_sd(tsc_sd), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready), .ts_data(ts_data),
    .ts_valid(ts_valid), .busy(busy), .err_timeout(err_timeout), .err_short(err_short),
    .state(state)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc = 0, n_last = 0, n_start = 0, n_tsv = 0;
  logic [8:0]  exp_q[$];
  logic [31:0] ts_q[$];
  int          adc_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int k = 0;
    while (state !== s && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a byte or timestamp
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (out_valid && out_ready) begin
          n_acc++;
          if (out_last) n_last++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL byte_unexpected: got 0x%0h, expected no byte", out_data);
          end else begin
            e = exp_q.pop_front();
            check("byte_data", 32'(out_data), 32'(e[8:1]));
            check("byte_last", 32'(out_last), 32'(e[0]));
          end
        end
        if (ts_valid) begin
          n_tsv++;
          if (ts_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ts_unexpected: got 0x%0h, expected no ts_valid", ts_data);
          end else begin
            check("ts_data", ts_data, ts_q.pop_front());
          end
        end
        if (tsc_start) n_start++;
        if (adc_req) begin
          adc_log.push_back(cyc);
          check("adc_in_wait", 32'(state == 3'd2 || state == 3'd3), 32'd1);
        end
      end
    end
  end

  // Cache model: offers bytes only while tsc_sbf is high.
  // sd_mode: 0 none, 1 send-done one cycle after the last byte, 2 with the last byte.
  task automatic cache_send(input int n, input int sd_mode, input int stall_lo,
                            input int stall_hi, input logic [7:0] base);
    int sent = 0;
    int k = 0;
    for (int i = 0; i < n; i++)
      exp_q.push_back({base + 8'(i), (i == CACHE_DEPTH - 1)});
    while (sent < n && k < 400) begin
      out_ready = !(k >= stall_lo && k < stall_hi);
      #1;
      if (out_valid && !out_ready) check("sbf_drop", 32'(tsc_sbf), 32'd0);
      if (tsc_sbf) begin
        tsc_rdy = 1'b1;
        tsc_dat = base + 8'(sent);
        sent++;
        tsc_sd = (sd_mode == 2 && sent == n);
      end else begin
        tsc_rdy = 1'b0;
      end
      tick();
      k++;
      tsc_rdy = 1'b0;
      tsc_sd  = 1'b0;
    end
    check("send_complete", 32'(sent), 32'(n));
    out_ready = 1'b1;
    if (sd_mode == 1) begin
      tsc_sd = 1'b1;
      tick();
      tsc_sd = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, a0, l0, s0, t0, k, bad;
    en = 0; tsc_trd = 0; tsc_cd = 0; tsc_trigtm = 0; tsc_rdy = 0; tsc_dat = 0;
    tsc_sd = 0; out_ready = 1;

    // Reset state
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'({adc_req, tsc_start, tsc_sbf, out_valid, out_last, ts_valid,
                           busy, err_timeout, err_short}), 32'd0);
    check("rst_ts", ts_data, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("idle_no_en", 32'(state), 32'd0);

    // Test 1: nominal frame
    s0 = n_start; t0 = n_tsv; a0 = n_acc; l0 = n_last;
    en = 1;
    wait_state(3'd2, 10, "t1_wait_trig");
    check("t1_one_start", 32'(n_start - s0), 32'd1);
    e0 = cyc;
    adc_log.delete();
    repeat (9) tick();
    tsc_trd = 1; tick(); tsc_trd = 0;
    check("t1_wait_cd", 32'(state), 32'd3);
    repeat (9) tick();
    tsc_cd = 1; tsc_trigtm = 32'h0000_1234; ts_q.push_back(32'h0000_1234);
    tick();
    tsc_cd = 0;
    check("t1_readout", 32'(state), 32'd4);
    check("t1_adc_count", 32'(adc_log.size()), 32'd4);
    for (int i = 0; i < adc_log.size(); i++)
      check("t1_adc_time", 32'(adc_log[i] - e0), 32'(4 * (i + 1)));
    cache_send(32, 0, 0, 0, 8'hA0);
    wait_state(3'd1, 10, "t1_back_arm");
    check("t1_bytes", 32'(n_acc - a0), 32'd32);
    check("t1_lasts", 32'(n_last - l0), 32'd1);
    check("t1_ts_pulses", 32'(n_tsv - t0), 32'd1);
    check("t1_ts_hold", ts_data, 32'h0000_1234);
    check("t1_no_short", 32'(err_short), 32'd0);

    // Test 2: downstream stall for 5 cycles
    a0 = n_acc; l0 = n_last;
    wait_state(3'd2, 10, "t2_wait_trig");
    tsc_trd = 1; tick(); tsc_trd = 0;
    tick();
    tsc_cd = 1; tsc_trigtm = 32'h0000_5678; ts_q.push_back(32'h0000_5678);
    tick();
    tsc_cd = 0;
    check("t2_readout", 32'(state), 32'd4);
    cache_send(32, 0, 5, 10, 8'h40);
    wait_state(3'd1, 10, "t2_back_arm");
    check("t2_bytes", 32'(n_acc - a0), 32'd32);
    check("t2_lasts", 32'(n_last - l0), 32'd1);

    // Test 3: trd+cd together, then short frame (send-done after 10 bytes)
    a0 = n_acc; l0 = n_last;
    wait_state(3'd2, 10, "t3_wait_trig");
    e0 = cyc;
    adc_log.delete();
    repeat (9) tick();
    tsc_trd = 1; tsc_cd = 1; tsc_trigtm = 32'hCAFE_0001; ts_q.push_back(32'hCAFE_0001);
    tick();
    tsc_trd = 0; tsc_cd = 0;
    check("t3_direct_readout", 32'(state), 32'd4);
    check("t3_adc_count", 32'(adc_log.size()), 32'd2);
    cache_send(10, 1, 0, 0, 8'h10);
    check("t3_drain", 32'(state), 32'd5);
    check("t3_err_short", 32'(err_short), 32'd1);
    wait_state(3'd1, 10, "t3_back_arm");
    check("t3_bytes", 32'(n_acc - a0), 32'd10);
    check("t3_no_last", 32'(n_last - l0), 32'd0);
    tick();
    check("t3_short_cleared", 32'(err_short), 32'd0);

    // Test 4: send-done together with the final byte is not short
    a0 = n_acc; l0 = n_last;
    tsc_trd = 1; tsc_cd = 1; tsc_trigtm = 32'h0000_0BEE; ts_q.push_back(32'h0000_0BEE);
    tick();
    tsc_trd = 0; tsc_cd = 0;
    cache_send(32, 2, 0, 0, 8'h60);
    wait_state(3'd1, 10, "t4_back_arm");
    check("t4_no_short", 32'(err_short), 32'd0);
    check("t4_bytes", 32'(n_acc - a0), 32'd32);
    check("t4_lasts", 32'(n_last - l0), 32'd1);

    // Test 5: capture-done never arrives
    wait_state(3'd2, 10, "t5_wait_trig");
    e0 = cyc;
    adc_log.delete();
    tick(); tick();
    tsc_trd = 1; tick(); tsc_trd = 0;
    check("t5_wait_cd", 32'(state), 32'd3);
    k = 0;
    while (state !== 3'd6 && k < 1100) begin
      tick();
      k++;
    end
    check("t5_timeout_cycles", 32'(k), 32'd1024);
    check("t5_err_timeout", 32'(err_timeout), 32'd1);
    check("t5_busy", 32'(busy), 32'd1);
    check("t5_adc_count", 32'(adc_log.size()), 32'd256);
    bad = 0;
    for (int i = 1; i < adc_log.size(); i++)
      if (adc_log[i] - adc_log[i-1] != SAMPLE_DIV) bad++;
    check("t5_adc_period", 32'(bad), 32'd0);
    if (adc_log.size() > 0) check("t5_adc_first", 32'(adc_log[0] - e0), 32'd4);
    en = 0;
    tick();
    check("t5_idle", 32'(state), 32'd0);
    check("t5_err_sticky", 32'(err_timeout), 32'd1);
    check("t5_not_busy", 32'(busy), 32'd0);

    // Test 6: asynchronous reset in the middle of readout
    en = 1;
    wait_state(3'd2, 10, "t6_wait_trig");
    check("t6_tmo_cleared", 32'(err_timeout), 32'd0);
    tsc_trd = 1; tsc_cd = 1; tsc_trigtm = 32'hDEAD_BEEF; ts_q.push_back(32'hDEAD_BEEF);
    tick();
    tsc_trd = 0; tsc_cd = 0;
    out_ready = 0; tsc_rdy = 1; tsc_dat = 8'h77;
    tick();
    tsc_rdy = 0;
    check("t6_held", 32'(out_valid), 32'd1);
    check("t6_ts", ts_data, 32'hDEAD_BEEF);
    a0 = n_acc;
    #3;
    reset = 1'b0;
    #1;
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_outs", 32'({adc_req, tsc_start, tsc_sbf, out_valid, out_last, ts_valid,
                              busy, err_timeout, err_short}), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_ts", ts_data, 32'd0);
    en = 0;
    tick();
    reset = 1'b1;
    out_ready = 1;
    repeat (5) tick();
    check("t6_stay_idle", 32'(state), 32'd0);
    check("t6_no_bytes", 32'(n_acc - a0), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("ts_q_empty", 32'(ts_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tsc_sequencer.md
TSC_SEQUENCER -- requirements
Module: tsc_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 4: clocks between adc_req pulses; legal range 2..255.
REQ-002 Parameter CACHE_DEPTH, default 32: bytes per readout frame; legal range 1..255.
REQ-003 Parameter TIMEOUT, default 1024: maximum cycles in WAIT_CD before the error path is taken.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  continuous-arm enable.
REQ-007 adc_req  out  1  one-cycle ADC sample request pulse.
REQ-008 tsc_start  out  1  one-cycle start pulse to the trigger-surround cache.
REQ-009 tsc_trd  in  1  cache trigger-detected flag.
REQ-010 tsc_cd  in  1  cache capture-done flag.
REQ-011 tsc_trigtm  in  32  trigger timestamp, valid while tsc_cd=1.
REQ-012 tsc_sbf  out  1  send-buffer request; the cache presents bytes only while it is high.
REQ-013 tsc_rdy  in  1  byte strobe, one byte per high cycle.
REQ-014 tsc_dat  in  8  byte data, valid while tsc_rdy=1.
REQ-015 tsc_sd  in  1  cache send-done flag.
REQ-016 out_valid, out_data[7:0], out_last  out  1/8/1  downstream byte stream.
REQ-017 out_ready  in  1  downstream accept.
REQ-018 ts_data  out  32  latched timestamp.
REQ-019 ts_valid  out  1  one-cycle pulse qualifying ts_data.
REQ-020 busy, err_timeout, err_short  out  1/1/1  status signals.
REQ-021 state  out  3  current state encoding.

Function
REQ-022 State encodings: IDLE=0, ARM=1, WAIT_TRIG=2, WAIT_CD=3, READOUT=4, DRAIN=5, ERROR=6.
REQ-023 IDLE: go to ARM when en=1.
REQ-024 ARM: tsc_start=1 for exactly this one cycle; clear err_timeout, err_short and the byte count; go to WAIT_TRIG.
REQ-025 WAIT_TRIG exits, highest priority first: tsc_trd=1 and tsc_cd=1 together -> latch timestamp, READOUT; tsc_trd=1 -> WAIT_CD; en=0 -> IDLE.
REQ-026 WAIT_CD: tsc_cd=1 -> latch timestamp, READOUT; else timeout counter reaches TIMEOUT-1 -> ERROR, set err_timeout; en=0 is ignored here.
REQ-027 Timestamp latch: ts_data <= tsc_trigtm; ts_valid=1 on the following cycle only.
REQ-028 adc_req pulse schedule: in WAIT_TRIG and WAIT_CD only; first pulse SAMPLE_DIV cycles after WAIT_TRIG entry, then every SAMPLE_DIV cycles; divider resets on WAIT_TRIG entry; never pulses in other states.
REQ-029 tsc_sbf = (state==READOUT) AND NOT (out_valid AND NOT out_ready).
REQ-030 Byte capture: tsc_rdy=1 with tsc_sbf=1 loads out_data <= tsc_dat, sets out_valid=1 and increments the 8-bit count; tsc_rdy while tsc_sbf=0 is ignored.
REQ-031 out_valid, out_data and out_last hold until out_valid AND out_ready; a same-cycle accept and new load is legal and causes no bubble.
REQ-032 out_last=1 with the byte for which count reaches CACHE_DEPTH; READOUT then exits to DRAIN.
REQ-033 tsc_sd=1 in READOUT with count < CACHE_DEPTH: set err_short, go to DRAIN.
REQ-034 tsc_sd together with a valid byte: capture the byte first; err_short is set only if count is still < CACHE_DEPTH after the capture.
REQ-035 DRAIN: stay while out_valid=1; once out_valid=0, go to ARM if en=1, else IDLE.
REQ-036 ERROR: go to IDLE when en=0; err_timeout stays set until the next ARM or reset.
REQ-037 busy=1 in every state except IDLE.
REQ-038 Timeout counter: 16 bits, saturating, cleared on WAIT_CD entry.

Reset
REQ-039 While reset=0, immediately and independent of clk: state=IDLE; all outputs 0; ts_data=0; count, divider and timeout counter = 0.
REQ-040 Reset asserted mid-frame abandons the frame; any byte not yet accepted is discarded and no out_last is issued.

Verification
REQ-041 en=1, trd at cycle 10, cd with trigtm=0x0000_1234 at cycle 20, 32 rdy strobes, out_ready=1 -> one tsc_start; ts_data=0x1234 with a ts_valid pulse; 32 bytes out; out_last on byte 32 only; back to ARM.
REQ-042 out_ready low for 5 cycles during READOUT -> tsc_sbf drops within the same cycle; no byte lost or duplicated; count ends at 32.
REQ-043 trd=1 then cd never asserted, TIMEOUT=1024 -> ERROR 1024 cycles after WAIT_CD entry; err_timeout=1; IDLE after en=0.
REQ-044 tsc_sd after 10 bytes -> err_short=1; 10 bytes delivered; out_last never set; DRAIN then ARM.
REQ-045 trd and cd in the same cycle -> WAIT_TRIG goes directly to READOUT; adc_req period is SAMPLE_DIV in WAIT_TRIG and WAIT_CD.
REQ-046 reset=0 mid-READOUT between clock edges -> all outputs 0 at once; state=0.
